// File: rtl/uart_pkg.sv
// Shared types and baud-rate helpers for the UART command receiver.
// UART_RX_CHECKSUM_EN adds the checksum state to the frame enum.
package uart_pkg;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  typedef enum logic [2:0] {
    F_HDR,
    F_CMD,
    F_DHI,
    F_DLO
`ifdef UART_RX_CHECKSUM_EN
    , F_CHK
`endif
  } frame_state_t;

  function automatic int calc_baud_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int bps);
    return calc_baud_cnt(clk_freq, bps) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop input synchronizer, start-bit qualification,
// LSB-first shift, stop-bit check with one-cycle valid / framing-error pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_CNT = 520,
  parameter int HALF_CNT = 260
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam int CNT_W = $clog2(BAUD_CNT);

  byte_state_t      r_state;
  byte_state_t      w_state_nxt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_byte_valid;
  logic             r_byte_ferr;
  logic             w_fall;
  logic             w_tick_half;
  logic             w_tick_full;
  logic             w_cnt_clr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall      = r_prev & ~r_sync2;
  assign w_tick_half = (r_cnt == CNT_W'(HALF_CNT - 1));
  assign w_tick_full = (r_cnt == CNT_W'(BAUD_CNT - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      B_IDLE:  if (w_fall) w_state_nxt = B_START;
      // A high line at mid start bit is a glitch: drop back silently.
      B_START: if (w_tick_half) w_state_nxt = r_sync2 ? B_IDLE : B_DATA;
      B_DATA:  if (w_tick_full && (r_bit_cnt == 3'd7)) w_state_nxt = B_STOP;
      B_STOP:  if (w_tick_full) w_state_nxt = B_IDLE;
      default: w_state_nxt = B_IDLE;
    endcase
  end

  assign w_cnt_clr = (r_state == B_IDLE) || (w_state_nxt != r_state) ||
                     ((r_state == B_DATA) && w_tick_full);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= B_IDLE;
      r_cnt        <= '0;
      r_bit_cnt    <= '0;
      r_byte_valid <= 1'b0;
      r_byte_ferr  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state == B_IDLE)
        r_bit_cnt <= '0;
      else if ((r_state == B_DATA) && w_tick_full)
        r_bit_cnt <= r_bit_cnt + 1'b1;
      // Stop bit is judged mid-bit so the next start edge is never missed.
      r_byte_valid <= (r_state == B_STOP) && w_tick_full &&  r_sync2;
      r_byte_ferr  <= (r_state == B_STOP) && w_tick_full && !r_sync2;
    end
  end

  always_ff @(posedge sys_clk) begin
    if ((r_state == B_DATA) && w_tick_full)
      r_shift <= {r_sync2, r_shift[7:1]};
  end

  assign byte_data  = r_shift;
  assign byte_valid = r_byte_valid;
  assign byte_ferr  = r_byte_ferr;

endmodule

// File: rtl/uart_rx_frame.sv
// Command frame receiver: HEADER, cmd, data hi, data lo [, XOR checksum].
// Define UART_RX_CHECKSUM_EN for the 5-byte checksummed frame.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int         CLK_FREQ     = 60_000_000,
  parameter int         UART_BPS     = 115200,
  parameter logic [7:0] HEADER       = HEADER_DEF,
  parameter int         TIMEOUT_BITS = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int BAUD_CNT = calc_baud_cnt(CLK_FREQ, UART_BPS);
  localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, UART_BPS);
  localparam int TO_CNT   = TIMEOUT_BITS * BAUD_CNT;
  localparam int TO_W     = $clog2(TO_CNT);

  frame_state_t    r_state;
  frame_state_t    w_state_nxt;
  logic [7:0]      w_byte_data;
  logic            w_byte_valid;
  logic            w_byte_ferr;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_timeout;
  logic            w_fv;
  logic            w_fe;
  logic [15:0]     w_commit_data;
  logic [7:0]      r_cmd_s;
  logic [7:0]      r_dhi_s;
  logic [7:0]      r_cmd;
  logic [15:0]     r_data;
  logic            r_frame_valid;
  logic            r_frame_err;
`ifdef UART_RX_CHECKSUM_EN
  logic [7:0]      r_dlo_s;
  logic            w_chk_ok;
`endif

  uart_rx_byte #(
    .BAUD_CNT (BAUD_CNT),
    .HALF_CNT (HALF_CNT)
  ) u_byte (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .uart_rxd   (uart_rxd),
    .byte_data  (w_byte_data),
    .byte_valid (w_byte_valid),
    .byte_ferr  (w_byte_ferr)
  );

  assign w_timeout = (r_state != F_HDR) && (r_to_cnt == TO_W'(TO_CNT - 1));

`ifdef UART_RX_CHECKSUM_EN
  assign w_chk_ok      = (w_byte_data == (r_cmd_s ^ r_dhi_s ^ r_dlo_s));
  assign w_commit_data = {r_dhi_s, r_dlo_s};
`else
  assign w_commit_data = {r_dhi_s, w_byte_data};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fv        = 1'b0;
    w_fe        = 1'b0;
    if ((r_state != F_HDR) && (w_byte_ferr || w_timeout)) begin
      w_state_nxt = F_HDR;
      w_fe        = 1'b1;
    end else if (w_byte_valid) begin
      case (r_state)
        // Only the header state resyncs; a HEADER value later on is payload.
        F_HDR: if (w_byte_data == HEADER) w_state_nxt = F_CMD;
        F_CMD: w_state_nxt = F_DHI;
        F_DHI: w_state_nxt = F_DLO;
`ifdef UART_RX_CHECKSUM_EN
        F_DLO: w_state_nxt = F_CHK;
        F_CHK: begin
          w_state_nxt = F_HDR;
          w_fv        = w_chk_ok;
          w_fe        = !w_chk_ok;
        end
`else
        F_DLO: begin
          w_state_nxt = F_HDR;
          w_fv        = 1'b1;
        end
`endif
        default: w_state_nxt = F_HDR;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= F_HDR;
      r_to_cnt      <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_cmd         <= '0;
      r_data        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_to_cnt      <= ((r_state == F_HDR) || w_byte_valid) ? '0 : r_to_cnt + 1'b1;
      r_frame_valid <= w_fv;
      r_frame_err   <= w_fe;
      if (w_fv) begin
        r_cmd  <= r_cmd_s;
        r_data <= w_commit_data;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_byte_valid) begin
      if (r_state == F_CMD) r_cmd_s <= w_byte_data;
      if (r_state == F_DHI) r_dhi_s <= w_byte_data;
`ifdef UART_RX_CHECKSUM_EN
      if (r_state == F_DLO) r_dlo_s <= w_byte_data;
`endif
    end
  end

  assign cmd         = r_cmd;
  assign data        = r_data;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign busy        = (r_state != F_HDR);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at a fast baud (16 clocks per bit) so
// whole frames, timeouts and resets fit in a short run.
module tb_uart_rx_frame;

  localparam int CLK_FREQ = 60_000_000;
  localparam int UART_BPS = 3_750_000;
  localparam int BAUD     = CLK_FREQ / UART_BPS;
  localparam int TO_CYC   = 32 * BAUD;
  localparam logic [7:0] HDR = 8'hA5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        uart_rxd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        frame_valid;
  logic        frame_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;

  uart_rx_frame #(
    .CLK_FREQ     (CLK_FREQ),
    .UART_BPS     (UART_BPS),
    .HEADER       (HDR),
    .TIMEOUT_BITS (32)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .uart_rxd    (uart_rxd),
    .cmd         (cmd),
    .data        (data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  typedef struct packed {
    logic [7:0] c;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] chk;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (BAUD) @(negedge sys_clk);
    for (int i = 0; i < nbits; i++) begin
      uart_rxd = b[i];
      repeat (BAUD) @(negedge sys_clk);
    end
    if (nbits == 8) begin
      uart_rxd = stop_bit;
      repeat (BAUD) @(negedge sys_clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8, 1'b1);
  endtask

  task automatic send_frame(input vec_t v);
    send_byte(HDR);
    send_byte(v.c);
    send_byte(v.hi);
    send_byte(v.lo);
`ifdef UART_RX_CHECKSUM_EN
    send_byte(v.chk);
`endif
  endtask

  function automatic logic frame_good(input vec_t v);
`ifdef UART_RX_CHECKSUM_EN
    return v.chk == (v.c ^ v.hi ^ v.lo);
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
    int fv0, fe0, cyc;
    logic seen, good;
    vec_t v;

    tbl[0] = '{c: 8'h01, hi: 8'h12, lo: 8'h34, chk: 8'h27};
    tbl[1] = '{c: 8'h01, hi: 8'h12, lo: 8'h34, chk: 8'h26};
    tbl[2] = '{c: 8'h7E, hi: 8'hA5, lo: 8'h5A, chk: 8'h81};
    tbl[3] = '{c: 8'hFF, hi: 8'h00, lo: 8'hFF, chk: 8'h00};
    tbl[4] = '{c: 8'hA5, hi: 8'hA5, lo: 8'hA5, chk: 8'hA5};

    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    sys_rst_n = 1'b1;
    repeat (20) @(negedge sys_clk);

    // Short low glitch on the idle line.
    uart_rxd = 1'b0;
    repeat (4) @(negedge sys_clk);
    uart_rxd = 1'b1;
    repeat (12 * BAUD) @(negedge sys_clk);
    check("glitch_fv", 32'(fv_cnt), 32'd0);
    check("glitch_fe", 32'(fe_cnt), 32'd0);
    check("glitch_busy", 32'(busy), 32'h0);

    // Junk bytes before the header are ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(tbl[0]);
    repeat (4) @(negedge sys_clk);
    check("lead_fe", 32'(fe_cnt), 32'd0);
    check("lead_fv", 32'(fv_cnt), 32'd1);
    check("lead_cmd", 32'(cmd), 32'h01);
    check("lead_data", 32'(data), 32'h1234);
    exp_cmd  = 8'h01;
    exp_data = 16'h1234;

    for (int i = 0; i < 5; i++) begin
      v    = tbl[i];
      good = frame_good(v);
      fv0  = fv_cnt;
      fe0  = fe_cnt;
      send_frame(v);
      repeat (4) @(negedge sys_clk);
      if (good) begin
        exp_cmd  = v.c;
        exp_data = {v.hi, v.lo};
      end
      check($sformatf("vec%0d_fv", i), 32'(fv_cnt - fv0), 32'(good));
      check($sformatf("vec%0d_fe", i), 32'(fe_cnt - fe0), 32'(!good));
      check($sformatf("vec%0d_cmd", i), 32'(cmd), 32'(exp_cmd));
      check($sformatf("vec%0d_data", i), 32'(data), 32'(exp_data));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // Inter-byte timeout after A5 01.
    fe0 = fe_cnt;
    fv0 = fv_cnt;
    send_byte(HDR);
    send_byte(8'h01);
    check("to_busy_mid", 32'(busy), 32'h1);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < TO_CYC + 4 * BAUD; i++) begin
      @(negedge sys_clk);
      cyc++;
      if (fe_cnt != fe0) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_seen", 32'(seen), 32'h1);
    check("to_window", 32'((cyc >= TO_CYC - 2 * BAUD) && (cyc <= TO_CYC)), 32'h1);
    repeat (2) @(negedge sys_clk);
    check("to_busy_after", 32'(busy), 32'h0);
    check("to_fv", 32'(fv_cnt - fv0), 32'd0);
    check("to_cmd", 32'(cmd), 32'(exp_cmd));

    // Framing error on the data-high byte.
    fe0 = fe_cnt;
    fv0 = fv_cnt;
    send_byte(HDR);
    send_byte(8'h33);
    send_bits(8'h44, 8, 1'b0);
    uart_rxd = 1'b1;
    repeat (2 * BAUD) @(negedge sys_clk);
    check("ferr_fe", 32'(fe_cnt - fe0), 32'd1);
    check("ferr_fv", 32'(fv_cnt - fv0), 32'd0);
    check("ferr_data", 32'(data), 32'(exp_data));
    check("ferr_busy", 32'(busy), 32'h0);

    // Reset asserted in the middle of the data-high byte.
    fe0 = fe_cnt;
    fv0 = fv_cnt;
    send_byte(HDR);
    send_byte(8'h5C);
    send_bits(8'h34, 4, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    check("mrst_cmd", 32'(cmd), 32'h0);
    check("mrst_data", 32'(data), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    uart_rxd = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3 * BAUD) @(negedge sys_clk);
    check("mrst_busy_idle", 32'(busy), 32'h0);
    v = '{c: 8'h3C, hi: 8'hBE, lo: 8'hEF, chk: 8'h3C ^ 8'hBE ^ 8'hEF};
    send_frame(v);
    repeat (4) @(negedge sys_clk);
    check("mrst_fv", 32'(fv_cnt - fv0), 32'd1);
    check("mrst_fe", 32'(fe_cnt - fe0), 32'd0);
    check("mrst_cmd2", 32'(cmd), 32'h3C);
    check("mrst_data2", 32'(data), 32'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
